ilowx_refill: RTL
=================

# ilowx_refill

Memory-side responder for the instruction-cache lower-level (lowX) refill interface. It accepts one line-fill request at a time from the instruction cache. It fetches the naturally aligned `BLK_SIZE`-bit line as `BLK_SIZE/32` sequential 32-bit word reads on a pipelined memory port, then returns the assembled line as a single-cycle `lowX_res.valid` pulse. It sits between `icache` and the instruction memory/bus fabric.

## Interface
- `BLK_SIZE`, default `tcore_param::BLK_SIZE` (128): line width in bits; multiple of 32; `WORDS = BLK_SIZE/32`.
- `XLEN`, default `tcore_param::XLEN` (32): address width.
- `clk_i` input, 1: clock; single clock domain.
- `rst_i` input, 1: reset, synchronous, active-high.
- `lowX_req_i` input, `ilowX_req_t`: `.valid` fill request (held by cache until served); `.ready` cache can accept a response; `.addr` miss address; `.uncached` attribute.
- `lowX_res_o` output, `ilowX_res_t`: `.valid` line-return pulse; `.blk` line data. Any other fields are driven 0.
- `mem_req_valid_o` output, 1: word read request.
- `mem_req_ready_i` input, 1: memory accepts request this cycle.
- `mem_req_addr_o` output, XLEN: word address, 4-byte aligned.
- `mem_req_uncached_o` output, 1: latched `.uncached` of the current fill.
- `mem_rsp_valid_i` input, 1: read data valid; responses in request order.
- `mem_rsp_data_i` input, 32: read data.
- `busy_o` output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, FETCH, RESP.
- **IDLE.** When `lowX_req_i.valid` is seen at a clock edge:
  - latch `base = {addr[XLEN-1:$clog2(BLK_SIZE/8)], 0}` and `uncached`;
  - clear `issue_cnt`, `recv_cnt` and the line buffer;
  - go to FETCH.
- **FETCH.**
  - Issue side: `mem_req_valid_o = (issue_cnt < WORDS)` and `mem_req_addr_o = base + 4*issue_cnt`. `issue_cnt` increments on `mem_req_valid_o && mem_req_ready_i`. Address and valid stay stable while ready is low.
  - Receive side: on `mem_rsp_valid_i`, write data to `buf[32*recv_cnt +: 32]` and increment `recv_cnt`. Word 0 occupies the LSBs.
  - Issue and receive proceed concurrently, so up to WORDS reads can be outstanding.
  - When the last word is captured (`recv_cnt == WORDS-1` and `mem_rsp_valid_i`), go to RESP.
- **RESP.**
  - `lowX_res_o.blk = buf` throughout.
  - `lowX_res_o.valid = lowX_req_i.ready`.
  - When `lowX_req_i.ready` is high, return to IDLE.
  - When `lowX_req_i.ready` is low, hold RESP with `buf` unchanged.
- Uncached requests fetch the full aligned line exactly like cached ones. The only difference is that `mem_req_uncached_o` is asserted for the duration of the fill.
- A latched fill always runs to completion, even if `lowX_req_i.valid` drops. `lowX_req_i.valid` is ignored outside IDLE.
- In IDLE and RESP, `mem_rsp_valid_i` is ignored and has no buffer or counter effect. A response beyond WORDS cannot occur by protocol.
- Counters are `$clog2(WORDS)+1` bits wide and do not wrap within a fill.

## Timing
- Reset values: state IDLE, `mem_req_valid_o=0`, `mem_req_addr_o=0`, `mem_req_uncached_o=0`, `lowX_res_o.valid=0`, `lowX_res_o.blk=0`, `busy_o=0`, counters 0.
- Reset mid-fill: abandon the fill and return to IDLE next cycle with all outputs at reset values. The memory side is reset by the same `rst_i`.
- Zero-wait memory (ready always 1, response one cycle after acceptance), request seen at the cycle-0 edge:
  - requests issue in cycles 1..WORDS;
  - responses arrive in cycles 2..WORDS+1;
  - `lowX_res_o.valid` is high in cycle WORDS+2 (cycle 6 for 128-bit lines).
- `lowX_res_o.valid` is a one-cycle pulse per fill. The earliest the next request can be accepted is the edge that ends the RESP cycle.
- No combinational path from `lowX_req_i` to `mem_req_*`. `lowX_res_o.valid` is combinational from `lowX_req_i.ready` only in RESP.

## Test plan
- **Basic fill.** Request addr 0x0000_1234, zero-wait memory returning `data = addr`:
  - word addresses 0x1230, 0x1234, 0x1238, 0x123C are issued;
  - `blk = {0x123C,0x1238,0x1234,0x1230}`;
  - `lowX_res_o.valid` pulses exactly once, in cycle 6.
- **Backpressure.** `mem_req_ready_i` low in cycles 2–3, and responses delayed by 3 cycles:
  - address is stable while stalled;
  - no word is duplicated or skipped;
  - the line is correct;
  - `lowX_res_o.valid` follows the final response by 1 cycle.
- **Response hold.** `lowX_req_i.ready=0` for 5 cycles on entry to RESP:
  - `lowX_res_o.valid` stays 0 and `blk` is stable;
  - the pulse occurs on the first ready-high cycle, then the block returns to IDLE.
- **Uncached.** Request 0x8000_0010 with `uncached=1`:
  - `mem_req_uncached_o=1` on all 4 requests and 0 afterward;
  - the full line is fetched from 0x8000_0010–0x8000_001C.
- **Reset mid-fill.** Assert `rst_i` after 2 words received:
  - next cycle all outputs are 0 and the block is in IDLE;
  - a following request to 0x40 fills correctly with no stale data.
- **Back-to-back.** Requests to 0x100 and then 0x200, the second valid the cycle after the first pulse:
  - two independent correct lines;
  - no stray `mem_rsp_valid_i` captured in IDLE.

Source files
------------

// File: rtl/ilowx_refill_if.sv
// Cache-side lowX refill handshake: fill request in, assembled line out.
interface ilowx_refill_if #(
  parameter int unsigned BLK_SIZE = 128,
  parameter int unsigned XLEN     = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [XLEN-1:0]     req_addr;
  logic                req_uncached;
  logic                res_valid;
  logic [BLK_SIZE-1:0] res_blk;

  modport master (
    output req_valid, req_ready, req_addr, req_uncached,
    input  res_valid, res_blk
  );

  modport slave (
    input  req_valid, req_ready, req_addr, req_uncached,
    output res_valid, res_blk
  );
endinterface

// File: rtl/ilowx_refill.sv
// Instruction-cache line refill responder: fetches an aligned line as
// sequential 32-bit reads on a pipelined memory port and returns it whole.
module ilowx_refill #(
  parameter int unsigned BLK_SIZE = 128,
  parameter int unsigned XLEN     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ilowx_refill_if.slave     lowx,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_req_addr_o,
  output logic              mem_req_uncached_o,
  input  logic              mem_rsp_valid_i,
  input  logic [31:0]       mem_rsp_data_i,
  output logic              busy_o
);
  localparam int unsigned WORDS = BLK_SIZE / 32;
  localparam int unsigned CNT_W = $clog2(WORDS) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     base_q;
  logic                uncached_q;
  logic [CNT_W-1:0]    issue_cnt_q, recv_cnt_q;
  logic [BLK_SIZE-1:0] line_q;
  logic                accept, issue_fire, capture;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    mem_req_valid_o    = 1'b0;
    mem_req_addr_o     = '0;
    mem_req_uncached_o = 1'b0;
    lowx.res_valid     = 1'b0;
    busy_o             = 1'b1;
    accept             = 1'b0;
    issue_fire         = 1'b0;
    capture            = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (lowx.req_valid) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_req_uncached_o = uncached_q;
        if (issue_cnt_q < CNT_W'(WORDS)) begin
          mem_req_valid_o = 1'b1;
          mem_req_addr_o  = base_q + (XLEN'(issue_cnt_q) << 2);
        end
        issue_fire = mem_req_valid_o && mem_req_ready_i;
        capture    = mem_rsp_valid_i;
        if (capture && recv_cnt_q == CNT_W'(WORDS - 1)) state_d = RESP;
      end
      RESP: begin
        lowx.res_valid = lowx.req_ready;
        if (lowx.req_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lowx.res_blk = line_q;

  // Issue and receive counters advance independently so reads can overlap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q      <= '0;
      uncached_q  <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      line_q      <= '0;
    end else begin
      if (accept) begin
        base_q      <= lowx.req_addr & ~XLEN'(BLK_SIZE / 8 - 1);
        uncached_q  <= lowx.req_uncached;
        issue_cnt_q <= '0;
        recv_cnt_q  <= '0;
        line_q      <= '0;
      end
      if (issue_fire) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      if (capture) begin
        for (int unsigned w = 0; w < WORDS; w++) begin
          if (recv_cnt_q == CNT_W'(w)) line_q[32*w +: 32] <= mem_rsp_data_i;
        end
        recv_cnt_q <= recv_cnt_q + CNT_W'(1);
      end
    end
  end
endmodule
